// File: rtl/writeback_stage_pkg.sv
// Shared constants for the MEM/WB writeback stage: writeback source encodings,
// load funct3 codes and the default datapath width.
package wb_pkg;

   localparam int XLEN_DEFAULT = 32;

   typedef enum logic [1:0] {
      WB_ALU  = 2'b00,
      WB_LOAD = 2'b01,
      WB_PC4  = 2'b10,
      WB_IMM  = 2'b11
   } wbsel_e;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   function automatic logic f3_is_legal_load(input logic [2:0] f3);
      return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
             (f3 == F3_LBU) || (f3 == F3_LHU);
   endfunction

endpackage

// File: rtl/writeback_stage_if.sv
// MEM-to-WB bundle plus the register-file write port and status seen by the
// rest of the core. The master side is the memory stage / core, slave is WB.
interface writeback_stage_if #(
   parameter int XLEN      = wb_pkg::XLEN_DEFAULT,
   parameter int CNT_WIDTH = 32
);
   logic                 mem_valid;
   logic                 mem_regwrite;
   logic [4:0]           mem_rd;
   logic [1:0]           mem_wbsel;
   logic [2:0]           mem_funct3;
   logic [1:0]           mem_addr_lo;
   logic [XLEN-1:0]      mem_alu_result;
   logic [XLEN-1:0]      mem_load_data;
   logic [XLEN-1:0]      mem_pc_plus4;
   logic [XLEN-1:0]      mem_imm;

   logic                 RegWrite_D;
   logic [4:0]           WriteRegister;
   logic [XLEN-1:0]      Writedata;
   logic                 wb_valid;
   logic                 wb_exception;
   logic [CNT_WIDTH-1:0] instret;

   modport master (
      output mem_valid, mem_regwrite, mem_rd, mem_wbsel, mem_funct3, mem_addr_lo,
             mem_alu_result, mem_load_data, mem_pc_plus4, mem_imm,
      input  RegWrite_D, WriteRegister, Writedata, wb_valid, wb_exception, instret
   );

   modport slave (
      input  mem_valid, mem_regwrite, mem_rd, mem_wbsel, mem_funct3, mem_addr_lo,
             mem_alu_result, mem_load_data, mem_pc_plus4, mem_imm,
      output RegWrite_D, WriteRegister, Writedata, wb_valid, wb_exception, instret
   );
endinterface

// File: rtl/writeback_stage_load_align.sv
// Combinational load extractor: picks the byte/halfword addressed by addr_lo,
// sign- or zero-extends it, and flags misaligned or unsupported load types.
module load_align
   import wb_pkg::*;
#(
   parameter int XLEN = XLEN_DEFAULT
) (
   input  logic [2:0]      i_funct3,
   input  logic [1:0]      i_addr_lo,
   input  logic [XLEN-1:0] i_raw,
   output logic [XLEN-1:0] o_value,
   output logic            o_misaligned,
   output logic            o_illegal
);

   logic [7:0]  w_lanes [4];
   logic [7:0]  w_byte;
   logic [15:0] w_half;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         assign w_lanes[gi] = i_raw[8*gi +: 8];
      end
   endgenerate

   assign w_byte = w_lanes[i_addr_lo];
   assign w_half = i_addr_lo[1] ? {w_lanes[3], w_lanes[2]} : {w_lanes[1], w_lanes[0]};

   always_comb begin
      o_value      = '0;
      o_misaligned = 1'b0;
      o_illegal    = !f3_is_legal_load(i_funct3);
      case (i_funct3)
         F3_LB:  o_value = {{(XLEN-8){w_byte[7]}}, w_byte};
         F3_LH: begin
            o_value      = {{(XLEN-16){w_half[15]}}, w_half};
            o_misaligned = i_addr_lo[0];
         end
         F3_LW: begin
            o_value      = i_raw;
            o_misaligned = (i_addr_lo != 2'b00);
         end
         F3_LBU: o_value = {{(XLEN-8){1'b0}}, w_byte};
         F3_LHU: begin
            o_value      = {{(XLEN-16){1'b0}}, w_half};
            o_misaligned = i_addr_lo[0];
         end
         default: o_value = '0;
      endcase
   end

endmodule

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register, writeback source mux, register-file write gating
// and retired-instruction counter.
module writeback_stage
   import wb_pkg::*;
#(
   parameter int XLEN      = XLEN_DEFAULT,
   parameter int CNT_WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   input  logic             flush,
   writeback_stage_if.slave bus
);

   logic                 r_valid;
   logic                 r_regwrite;
   logic [4:0]           r_rd;
   wbsel_e               r_wbsel;
   logic [2:0]           r_funct3;
   logic [1:0]           r_addr_lo;
   logic [XLEN-1:0]      r_alu_result;
   logic [XLEN-1:0]      r_load_data;
   logic [XLEN-1:0]      r_pc_plus4;
   logic [XLEN-1:0]      r_imm;
   logic [CNT_WIDTH-1:0] r_instret;

   logic [XLEN-1:0]      w_load_value;
   logic                 w_misaligned;
   logic                 w_illegal;
   logic                 w_load_bad;
   logic                 w_exception;
   logic [XLEN-1:0]      w_writedata;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid      <= 1'b0;
         r_regwrite   <= 1'b0;
         r_rd         <= '0;
         r_wbsel      <= WB_ALU;
         r_funct3     <= '0;
         r_addr_lo    <= '0;
         r_alu_result <= '0;
         r_load_data  <= '0;
         r_pc_plus4   <= '0;
         r_imm        <= '0;
      end else if (flush) begin
         r_valid    <= 1'b0;
         r_regwrite <= 1'b0;
      end else if (!stall) begin
         r_valid      <= bus.mem_valid;
         r_regwrite   <= bus.mem_regwrite;
         r_rd         <= bus.mem_rd;
         r_wbsel      <= wbsel_e'(bus.mem_wbsel);
         r_funct3     <= bus.mem_funct3;
         r_addr_lo    <= bus.mem_addr_lo;
         r_alu_result <= bus.mem_alu_result;
         r_load_data  <= bus.mem_load_data;
         r_pc_plus4   <= bus.mem_pc_plus4;
         r_imm        <= bus.mem_imm;
      end
   end

   // An instruction retires when it leaves WB; a flush does not stop that.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_instret <= '0;
      end else if (r_valid && !stall && !w_exception) begin
         r_instret <= r_instret + CNT_WIDTH'(1);
      end
   end

   load_align #(.XLEN(XLEN)) u_load_align (
      .i_funct3     (r_funct3),
      .i_addr_lo    (r_addr_lo),
      .i_raw        (r_load_data),
      .o_value      (w_load_value),
      .o_misaligned (w_misaligned),
      .o_illegal    (w_illegal)
   );

   assign w_load_bad  = (r_wbsel == WB_LOAD) && (w_misaligned || w_illegal);
   assign w_exception = r_valid && w_load_bad;

   always_comb begin
      w_writedata = r_alu_result;
      case (r_wbsel)
         WB_ALU:  w_writedata = r_alu_result;
         WB_LOAD: w_writedata = w_load_bad ? '0 : w_load_value;
         WB_PC4:  w_writedata = r_pc_plus4;
         WB_IMM:  w_writedata = r_imm;
      endcase
   end

   assign bus.RegWrite_D    = r_valid && r_regwrite && (r_rd != 5'd0) && !w_exception;
   assign bus.WriteRegister = r_rd;
   assign bus.Writedata     = w_writedata;
   assign bus.wb_valid      = r_valid;
   assign bus.wb_exception  = w_exception;
   assign bus.instret       = r_instret;

endmodule

// File: doc/writeback_stage.md
# writeback_stage

MEM/WB pipeline register and writeback logic for the RISC-V core. It latches the memory-stage result bundle and selects the writeback source. It aligns and extends load data, then drives the register file write port (`RegWrite_D`, `WriteRegister`, `Writedata`). It also supplies the forwarding copy of the writeback value and keeps a retired-instruction counter.

## Interface
Parameters:
- `XLEN`, default 32: datapath width.
- `CNT_WIDTH`, default 32: width of the retire counter.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `stall`, in, 1: hold the MEM/WB register.
- `flush`, in, 1: load a bubble into the MEM/WB register.
- `mem_valid`, in, 1: the MEM bundle holds a real instruction.
- `mem_regwrite`, in, 1: the instruction writes rd.
- `mem_rd`, in, 5: destination register.
- `mem_wbsel`, in, 2: writeback source. 00 = ALU, 01 = load, 10 = PC+4, 11 = immediate (LUI).
- `mem_funct3`, in, 3: load type.
- `mem_addr_lo`, in, 2: low bits of the load address.
- `mem_alu_result`, in, XLEN: ALU result.
- `mem_load_data`, in, XLEN: raw aligned data-memory word.
- `mem_pc_plus4`, in, XLEN: PC+4.
- `mem_imm`, in, XLEN: immediate.
- `RegWrite_D`, out, 1: register file write enable.
- `WriteRegister`, out, 5: register file write address.
- `Writedata`, out, XLEN: register file write data; also the forwarding value.
- `wb_valid`, out, 1: the WB stage holds a real instruction.
- `wb_exception`, out, 1: the WB instruction is a misaligned or illegal load.
- `instret`, out, CNT_WIDTH: retired-instruction count.

## Operation
- MEM/WB register fields: valid, regwrite, rd, wbsel, funct3, addr_lo, alu_result, load_data, pc_plus4, imm.
- Register update priority: `rst` > `flush` > `stall` > capture.
  - `flush` clears valid and regwrite and leaves the other fields don't-care.
  - `stall` holds every field.
- Writeback source selection is combinational from the registered fields:
  - 00: `Writedata` = alu_result.
  - 01: `Writedata` = aligned load value.
  - 10: `Writedata` = pc_plus4.
  - 11: `Writedata` = imm.
- Load alignment when wbsel = 01:
  - LB (000): byte at addr_lo, sign-extended.
  - LH (001): halfword at addr_lo[1], sign-extended.
  - LW (010): full word.
  - LBU (100): byte at addr_lo, zero-extended.
  - LHU (101): halfword at addr_lo[1], zero-extended.
- Exception conditions when wbsel = 01:
  - Misaligned: LH/LHU with addr_lo[0] = 1, or LW with addr_lo ≠ 00.
  - Illegal: funct3 of 011, 110 or 111.
  - Either condition asserts `wb_exception` and sets `Writedata` = 0.
- `RegWrite_D` = valid & regwrite & (rd ≠ 0) & ~wb_exception.
  - A write to x0 never reaches the register file.
- `WriteRegister` = registered rd, always driven.
- `wb_valid` = registered valid.
- During a stall, `RegWrite_D` stays asserted with unchanged address and data. The repeated write is idempotent.
- `instret` increments by 1 on each rising edge where `wb_valid` & ~`stall` & ~`wb_exception`, i.e. when the instruction leaves WB.
  - It wraps from 2^CNT_WIDTH−1 to 0.
  - `flush` does not affect `instret`; a flushed-out WB instruction still counts if it is leaving.

## Timing
- A MEM bundle present before edge N is captured at edge N.
- `RegWrite_D`, `WriteRegister` and `Writedata` are valid combinationally after edge N. The register file commits at edge N+1.
- `Writedata` is combinational from registered state, so it is usable for same-cycle forwarding to EX.
- Reset values: `RegWrite_D` 0, `WriteRegister` 0, `Writedata` 0, `wb_valid` 0, `wb_exception` 0, `instret` 0.
- Reset mid-operation discards the in-flight instruction; it is not counted.
- When `flush` and `stall` are asserted together, the flush wins and a bubble is loaded.
- There are no multi-cycle paths and no internal state machine beyond the pipeline register and counter.

## Structure
- Shared package `wb_pkg` holds:
  - WBSEL encodings: WB_ALU, WB_LOAD, WB_PC4, WB_IMM.
  - Load funct3 constants: F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU.
  - XLEN default.
- Sub-module `load_align` (combinational).
  - Inputs: funct3, addr_lo, raw word.
  - Outputs: extended value, misaligned flag, illegal flag.
- Top module contains the pipeline register, source mux, write-enable gating and `instret` counter.

## Test plan
- ALU op, rd = 5, alu_result = 0x0000_1234, regwrite = 1, single cycle:
  - One cycle after capture: `RegWrite_D` = 1, `WriteRegister` = 5, `Writedata` = 0x1234.
  - `instret` = 1 after the next edge.
- Loads with load_data = 0x80FF_7F01:
  - LB at addr_lo 3 gives 0xFFFF_FF80.
  - LBU at addr_lo 1 gives 0x0000_007F.
  - LH at addr_lo 2 gives 0xFFFF_80FF.
  - LHU at addr_lo 0 gives 0x0000_7F01.
  - LW at addr_lo 0 gives 0x80FF_7F01.
- LW at addr_lo 2, and funct3 = 011:
  - Each gives `wb_exception` = 1, `RegWrite_D` = 0, `Writedata` = 0.
  - `instret` unchanged.
- rd = 0 with regwrite = 1 and alu_result = 0xDEAD_BEEF:
  - `RegWrite_D` = 0; `instret` still increments.
- Stall for 3 cycles on a valid ALU op:
  - Outputs hold stable and `instret` is unchanged until the release edge, then +1.
  - `flush` together with `stall` yields `wb_valid` = 0 next cycle.
- Reset and wrap:
  - With `instret` preset by driving 2^32−1 retirements (or by forcing the counter), one more retirement gives `instret` = 0.
  - Asserting `rst` mid-stream clears every output to 0 at the next edge.
